// File: rtl/exu_pkg.sv
// exu_pkg: shared encodings for the execute-response stage.
//   ALU operation codes, operand-select codes, branch compare codes,
//   FSM state type and the reset PC.
// Ports: none (package).
package exu_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2,
        SRC1_ZER3 = 2'd3
    } src1_sel_e;

    typedef enum logic [1:0] {
        SRC2_RS2  = 2'd0,
        SRC2_IMM  = 2'd1,
        SRC2_FOUR = 2'd2,
        SRC2_ZERO = 2'd3
    } src2_sel_e;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd0,
        CMP_NE  = 3'd1,
        CMP_LT  = 3'd4,
        CMP_GE  = 3'd5,
        CMP_LTU = 3'd6,
        CMP_GEU = 3'd7
    } cmp_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } exu_state_e;

endpackage

// File: rtl/exu_alu.sv
// exu_alu: combinational execute datapath.
//   Operand muxes, ALU, branch comparator and redirect target adder.
// Ports:
//   pcX, src1X, src2X, immX     in  32   bundle operands
//   ALU_opX, ALUsrc1X, ALUsrc2X in       ALU op and operand selects
//   cmp_typeX, branchX, jumpX, jalrX in  control-flow fields
//   alures  out 32  ALU result
//   taken   out 1   control-flow transfer taken
//   target  out 32  redirect target
// Macro CONFIG_EXU_REDIRECT_EN: when undefined the comparator and target
// adder are not built; taken is 0 and target is the reset PC.
import exu_pkg::*;

module exu_alu (
    input  logic [31:0] pcX,
    input  logic [31:0] src1X,
    input  logic [31:0] src2X,
    input  logic [31:0] immX,
    input  logic [2:0]  ALU_opX,
    input  logic [1:0]  ALUsrc1X,
    input  logic [1:0]  ALUsrc2X,
    input  logic [2:0]  cmp_typeX,
    input  logic        branchX,
    input  logic        jumpX,
    input  logic        jalrX,
    output logic [31:0] alures,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;

    always_comb begin
        op_a = 32'd0;
        case (src1_sel_e'(ALUsrc1X))
            SRC1_RS1: op_a = src1X;
            SRC1_PC:  op_a = pcX;
            default:  op_a = 32'd0;
        endcase
    end

    always_comb begin
        op_b = 32'd0;
        case (src2_sel_e'(ALUsrc2X))
            SRC2_RS2:  op_b = src2X;
            SRC2_IMM:  op_b = immX;
            SRC2_FOUR: op_b = 32'd4;
            default:   op_b = 32'd0;
        endcase
    end

    assign shamt = op_b[4:0];

    always_comb begin
        alures = 32'd0;
        case (alu_op_e'(ALU_opX))
            ALU_ADD: alures = op_a + op_b;
            ALU_SUB: alures = op_a - op_b;
            ALU_AND: alures = op_a & op_b;
            ALU_OR:  alures = op_a | op_b;
            ALU_XOR: alures = op_a ^ op_b;
            ALU_SLL: alures = op_a << shamt;
            ALU_SRL: alures = op_a >> shamt;
            ALU_SRA: alures = $unsigned($signed(op_a) >>> shamt);
            default: alures = 32'd0;
        endcase
    end

`ifdef CONFIG_EXU_REDIRECT_EN
    logic        cmp_true;
    logic [31:0] jalr_sum;

    always_comb begin
        cmp_true = 1'b0;
        case (cmp_e'(cmp_typeX))
            CMP_EQ:  cmp_true = (src1X == src2X);
            CMP_NE:  cmp_true = (src1X != src2X);
            CMP_LT:  cmp_true = ($signed(src1X) <  $signed(src2X));
            CMP_GE:  cmp_true = ($signed(src1X) >= $signed(src2X));
            CMP_LTU: cmp_true = (src1X <  src2X);
            CMP_GEU: cmp_true = (src1X >= src2X);
            default: cmp_true = 1'b0;
        endcase
    end

    assign jalr_sum = src1X + immX;
    assign taken    = jumpX | (branchX & cmp_true);
    // JALR target clears bit 0 of the sum.
    assign target   = jalrX ? (jalr_sum & 32'hFFFF_FFFE) : (pcX + immX);
`else
    logic unused_redirect;
    assign unused_redirect = ^{cmp_typeX, branchX, jumpX, jalrX};
    assign taken  = 1'b0;
    assign target = RESET_PC;
`endif

endmodule

// File: rtl/exu_resp.sv
// exu_resp: execute stage with a one-deep result register and
// valid/ready handshakes on both sides.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | empty, s_ready high, waiting for a bundle
//   ST_HOLD | result held, m_valid high until m_ready
//
// Ports:
//   clk, rst                 in   clock, synchronous active-high reset
//   s_valid / s_ready        in/out upstream handshake
//   pcX..rdX                 in   X-stage bundle
//   m_valid / m_ready        out/in downstream handshake
//   aluresE, rdE, pcE        out  held result
//   redirect_valid, redirect_pc out  control-flow redirect
// Macro CONFIG_EXU_REDIRECT_EN enables the redirect outputs; when undefined
// they are tied to 0 and the reset PC.
import exu_pkg::*;

module exu_resp (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] pcX,
    input  logic [31:0] snpcX,
    input  logic [31:0] src1X,
    input  logic [31:0] src2X,
    input  logic [31:0] immX,
    input  logic [2:0]  ALU_opX,
    input  logic [1:0]  ALUsrc1X,
    input  logic [1:0]  ALUsrc2X,
    input  logic [2:0]  cmp_typeX,
    input  logic        branchX,
    input  logic        jumpX,
    input  logic        jalrX,
    input  logic [4:0]  rdX,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] aluresE,
    output logic [4:0]  rdE,
    output logic [31:0] pcE,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    exu_state_e  state;
    logic [31:0] alures;
    logic        taken;
    logic [31:0] target;

    // snpcX is carried in the bundle but not consumed by this stage.
    logic unused_snpc;
    assign unused_snpc = ^snpcX;

    exu_alu u_alu (
        .pcX       (pcX),
        .src1X     (src1X),
        .src2X     (src2X),
        .immX      (immX),
        .ALU_opX   (ALU_opX),
        .ALUsrc1X  (ALUsrc1X),
        .ALUsrc2X  (ALUsrc2X),
        .cmp_typeX (cmp_typeX),
        .branchX   (branchX),
        .jumpX     (jumpX),
        .jalrX     (jalrX),
        .alures    (alures),
        .taken     (taken),
        .target    (target)
    );

    assign s_ready = (state == ST_IDLE);
    assign m_valid = (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            aluresE <= 32'd0;
            rdE     <= 5'd0;
            pcE     <= RESET_PC;
`ifdef CONFIG_EXU_REDIRECT_EN
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        state   <= ST_HOLD;
                        aluresE <= alures;
                        rdE     <= rdX;
                        pcE     <= pcX;
`ifdef CONFIG_EXU_REDIRECT_EN
                        redirect_valid <= taken;
                        if (taken)
                            redirect_pc <= target;
`endif
                    end
                end
                ST_HOLD: begin
`ifdef CONFIG_EXU_REDIRECT_EN
                    // Redirect is a single pulse on the first HOLD cycle.
                    redirect_valid <= 1'b0;
`endif
                    if (m_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef CONFIG_EXU_REDIRECT_EN
    logic unused_target;
    assign unused_target  = ^{taken, target};
    assign redirect_valid = 1'b0;
    assign redirect_pc    = RESET_PC;
`endif

endmodule

// File: doc/exu_resp.md
EXU_RESP -- requirements
Module: exu_resp

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have inputs, upstream handshake: s_valid in 1 (X bundle valid); s_ready out 1 (EXU can accept).
REQ-004 SHALL have bundle inputs: pcX 32, snpcX 32, src1X 32, src2X 32, immX 32, ALU_opX 3, ALUsrc1X 2, ALUsrc2X 2, cmp_typeX 3, branchX 1, jumpX 1, jalrX 1, rdX 5.
REQ-005 SHALL have downstream handshake: m_valid out 1 (result held); m_ready in 1 (M stage accepts).
REQ-006 SHALL have outputs: aluresE out 32 (ALU result); rdE out 5; pcE out 32; redirect_valid out 1; redirect_pc out 32.

Function
REQ-007 SHALL implement a 2-state FSM: IDLE, HOLD; s_ready = (state==IDLE); m_valid = (state==HOLD).
REQ-008 SHALL go IDLE->HOLD when s_valid; HOLD->IDLE when m_ready; otherwise hold state.
REQ-009 SHALL latch aluresE, rdE, pcE only on s_valid & s_ready; outputs stable throughout HOLD.
REQ-010 SHALL give one-cycle latency: result visible the cycle after acceptance; max throughput one bundle per two cycles.
REQ-011 SHALL ignore m_ready in IDLE and s_valid in HOLD (no bundle overwrite, no drop).
REQ-012 SHALL select operand A by ALUsrc1X: 0 src1X, 1 pcX, 2/3 zero.
REQ-013 SHALL select operand B by ALUsrc2X: 0 src2X, 1 immX, 2 constant 4, 3 zero.
REQ-014 SHALL compute by ALU_opX: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA; shift amount B[4:0]; all arithmetic modulo 2^32.
REQ-015 SHALL compare src1X/src2X by cmp_typeX: 0 EQ, 1 NE, 4 LT signed, 5 GE signed, 6 LTU, 7 GEU; codes 2/3 evaluate false.
REQ-016 SHALL define taken = jumpX | (branchX & cmp_true).
REQ-017 SHALL define target = jalrX ? ((src1X+immX) & ~1) : (pcX+immX), wrapping modulo 2^32.

Reset
REQ-018 SHALL on rst: state IDLE; aluresE 0; rdE 0; pcE 32'h80000000; redirect_valid 0; redirect_pc 32'h80000000.
REQ-019 SHALL on rst asserted in HOLD discard held bundle; m_valid low next cycle; no redirect emitted.
REQ-020 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-021 SHALL use macro CONFIG_EXU_REDIRECT_EN.
REQ-022 SHALL when defined: on acceptance with taken=1, register redirect_valid=1 and redirect_pc=target for exactly the first HOLD cycle; with taken=0, redirect_valid stays 0.
REQ-023 SHALL when undefined: redirect_valid tied 0, redirect_pc tied 32'h80000000, comparator and target adder absent; FSM and ALU behaviour unchanged.

Structure
REQ-024 SHALL place ALU_op, ALUsrc, cmp_type encodings and reset PC 32'h80000000 in shared package exu_pkg.
REQ-025 SHALL isolate datapath in one combinational sub-module exu_alu (operand muxes, ALU, comparator, target); exu_resp holds FSM and registers.

Verification
REQ-026 SHALL cover ADD: src1=5, src2=7, ALU_op=0, srcsel 0/0, s_valid 1 cycle, m_ready=1 -> next cycle m_valid=1, aluresE=12; following cycle IDLE, s_ready=1.
REQ-027 SHALL cover backpressure: accept SUB 3-5, m_ready=0 for 4 cycles -> aluresE=32'hFFFFFFFE held, s_ready=0, new s_valid ignored; m_ready=1 -> IDLE next cycle.
REQ-028 SHALL cover SRA: src1=32'h80000000, imm=35, ALUsrc2=1, op=7 -> aluresE=32'hF0000000 (shamt 3).
REQ-029 SHALL cover redirect (macro on): BGE branch=1, cmp=5, src1=-1, src2=-2, pc=32'h80000010, imm=-16 -> redirect_valid=1 one cycle, redirect_pc=32'h80000000; cmp=4 same operands -> redirect_valid=0.
REQ-030 SHALL cover JALR: jalr=1, jump=1, src1=32'h80001003, imm=0 -> redirect_pc=32'h80001002; ALUsrc1=1, ALUsrc2=2 -> aluresE=pc+4.
REQ-031 SHALL cover rst asserted during HOLD -> next cycle m_valid=0, aluresE=0, rdE=0, redirect_valid=0.
